// File: rtl/zone_light_pkg.sv
// Shared constants, mode encodings and FSM state type for the zone backlight calculator.
package zone_light_pkg;

  localparam int H_ACT_DEF     = 1920;
  localparam int V_ACT_DEF     = 1080;
  localparam int ZONE_COLS_DEF = 24;
  localparam int ZONE_ROWS_DEF = 15;
  localparam int NUM_ZONES     = 360;
  localparam int ZONE_W        = H_ACT_DEF / ZONE_COLS_DEF;
  localparam int ZONE_H        = V_ACT_DEF / ZONE_ROWS_DEF;
  localparam int LIGHT_W       = 8;

  typedef enum logic [1:0] {
    MODE_FILT = 2'd0,
    MODE_RAW  = 2'd1,
    MODE_FULL = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/zone_iir_clamp.sv
// Per-zone commit datapath: temporal IIR / mode override, then the MIN_LIGHT floor.
module zone_iir_clamp
  import zone_light_pkg::*;
#(
  parameter int FILT_SH   = 2,
  parameter int MIN_LIGHT = 8
) (
  input  logic [LIGHT_W-1:0] o,
  input  logic [LIGHT_W-1:0] r,
  input  mode_e              mode,
  output logic [LIGHT_W-1:0] w
);

  localparam int                 ACC_W     = LIGHT_W + FILT_SH;
  localparam logic [ACC_W-1:0]   HIST_GAIN = ACC_W'((1 << FILT_SH) - 1);
  localparam logic [LIGHT_W-1:0] FLOOR     = LIGHT_W'(MIN_LIGHT);

  // With FILT_SH=0 the history gain is zero and the result collapses to r.
  function automatic logic [LIGHT_W-1:0] iir(input logic [LIGHT_W-1:0] hist,
                                             input logic [LIGHT_W-1:0] cur);
    logic [ACC_W-1:0] acc;
    acc = ACC_W'(hist) * HIST_GAIN + ACC_W'(cur);
    return acc[ACC_W-1:FILT_SH];
  endfunction

  function automatic logic [LIGHT_W-1:0] floor_light(input logic [LIGHT_W-1:0] v);
    return (v < FLOOR) ? FLOOR : v;
  endfunction

  logic [LIGHT_W-1:0] f;

  always_comb begin
    f = o;
    case (mode)
      MODE_FILT: f = iir(o, r);
      MODE_RAW:  f = r;
      MODE_FULL: f = '1;
      MODE_HOLD: f = o;
      default:   f = o;
    endcase
    w = floor_light(f);
  end

endmodule

// File: rtl/zone_light_calc.sv
// Per-zone peak-luma statistics over the active video, committed once per frame
// into the flattened LED level vector through the IIR/mode/clamp datapath.
module zone_light_calc
  import zone_light_pkg::*;
#(
  parameter int H_ACT     = H_ACT_DEF,
  parameter int V_ACT     = V_ACT_DEF,
  parameter int ZONE_COLS = ZONE_COLS_DEF,
  parameter int ZONE_ROWS = ZONE_ROWS_DEF,
  parameter int FILT_SH   = 2,
  parameter int MIN_LIGHT = 8
) (
  input  logic                           I_clk,
  input  logic                           I_rst,
  input  logic                           I_vs,
  input  logic                           I_de,
  input  logic [7:0]                     I_luma,
  input  logic [1:0]                     I_mode,
  output logic [LIGHT_W*NUM_ZONES-1:0]   O_led_light,
  output logic                           O_frame_done,
  output logic                           O_frame_err,
  output logic                           O_busy
);

  localparam int ZW  = H_ACT / ZONE_COLS;
  localparam int ZH  = V_ACT / ZONE_ROWS;
  localparam int XW  = $clog2(H_ACT + 2);
  localparam int LW  = $clog2(V_ACT + 2);
  localparam int SW  = $clog2(ZW + 1);
  localparam int CW  = $clog2(ZONE_COLS + 1);
  localparam int CIW = $clog2(ZONE_COLS);
  localparam int ZLW = $clog2(ZH + 1);
  localparam int ZRW = $clog2(ZONE_ROWS + 1);
  localparam int KW  = $clog2(NUM_ZONES);

  if ((H_ACT % ZONE_COLS) != 0 || (V_ACT % ZONE_ROWS) != 0 ||
      (ZONE_COLS * ZONE_ROWS) != NUM_ZONES) begin : g_bad_geometry
    $error("zone_light_calc: zone grid must tile the active area exactly into 360 zones");
  end

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic               vs_d, de_d, vs_pend_q, bad_q;
  logic [XW-1:0]      x_cnt;
  logic [SW-1:0]      sub_cnt;
  logic [CW-1:0]      col_cnt;
  logic [LW-1:0]      line_cnt;
  logic [ZLW-1:0]     zline_cnt;
  logic [ZRW-1:0]     zrow_cnt;
  logic [KW-1:0]      k_q;
  logic [LIGHT_W-1:0] run_max_q [ZONE_COLS];
  logic [LIGHT_W-1:0] raw_q     [NUM_ZONES];
  logic [LIGHT_W-1:0] led_q     [NUM_ZONES];
  logic [LIGHT_W-1:0] commit_val;
  logic               done_q, err_q;

  logic vs_rise, frame_ok, frame_start, start_commit, err_d;
  logic acc_en, line_in_range, pix_ok, line_end, row_close, mark_bad;

  assign vs_rise       = I_vs & ~vs_d;
  assign frame_ok      = (line_cnt == LW'(V_ACT)) && !bad_q;
  assign line_in_range = line_cnt < LW'(V_ACT);

  always_comb begin
    state_d      = state_q;
    frame_start  = 1'b0;
    start_commit = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise) begin
          state_d     = ST_ACC;
          frame_start = 1'b1;
        end
      end
      ST_ACC: begin
        if (vs_rise || vs_pend_q) begin
          frame_start = 1'b1;
          if (frame_ok) begin
            state_d      = ST_COMMIT;
            start_commit = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        if (k_q == KW'(NUM_ZONES - 1)) state_d = ST_ACC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign acc_en    = (state_q == ST_ACC) && !frame_start;
  assign pix_ok    = acc_en && I_de && line_in_range && (x_cnt < XW'(H_ACT));
  assign line_end  = acc_en && de_d && !I_de;
  assign row_close = line_end && line_in_range && (zline_cnt == ZLW'(ZH - 1));
  assign mark_bad  = (acc_en && I_de && !line_in_range) ||
                     (line_end && (x_cnt != XW'(H_ACT))) ||
                     ((state_q == ST_COMMIT) && I_de);

  // Control: FSM, edge detectors, counters and event pulses
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_FILT;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      vs_pend_q <= 1'b0;
      bad_q     <= 1'b0;
      x_cnt     <= '0;
      sub_cnt   <= '0;
      col_cnt   <= '0;
      line_cnt  <= '0;
      zline_cnt <= '0;
      zrow_cnt  <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_d    <= I_vs;
      de_d    <= I_de;
      done_q  <= (state_q == ST_COMMIT) && (k_q == KW'(NUM_ZONES - 1));
      err_q   <= err_d;

      if (state_q == ST_COMMIT && vs_rise) vs_pend_q <= 1'b1;
      else if (state_q == ST_ACC && frame_start) vs_pend_q <= 1'b0;

      if (start_commit) begin
        mode_q <= mode_e'(I_mode);
        k_q    <= '0;
      end else if (state_q == ST_COMMIT) begin
        k_q <= k_q + 1'b1;
      end

      if (frame_start) begin
        bad_q     <= 1'b0;
        x_cnt     <= '0;
        sub_cnt   <= '0;
        col_cnt   <= '0;
        line_cnt  <= '0;
        zline_cnt <= '0;
        zrow_cnt  <= '0;
      end else begin
        if (mark_bad) bad_q <= 1'b1;
        if (line_end) begin
          x_cnt   <= '0;
          sub_cnt <= '0;
          col_cnt <= '0;
          if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
          if (line_in_range) zline_cnt <= row_close ? '0 : zline_cnt + 1'b1;
          if (row_close) zrow_cnt <= zrow_cnt + 1'b1;
        end else if (acc_en && I_de) begin
          // x keeps counting past H_ACT (saturating) so over-long lines are caught
          if (x_cnt <= XW'(H_ACT)) x_cnt <= x_cnt + 1'b1;
          if (pix_ok) begin
            if (sub_cnt == SW'(ZW - 1)) begin
              sub_cnt <= '0;
              col_cnt <= col_cnt + 1'b1;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  // Running column maxima and the raw per-zone store
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int c = 0; c < ZONE_COLS; c++) run_max_q[CIW'(c)] <= '0;
      for (int z = 0; z < NUM_ZONES; z++) raw_q[KW'(z)] <= '0;
    end else begin
      for (int c = 0; c < ZONE_COLS; c++) begin
        if (frame_start) begin
          run_max_q[CIW'(c)] <= '0;
        end else if (row_close) begin
          raw_q[KW'(int'(zrow_cnt) * ZONE_COLS + c)] <= run_max_q[CIW'(c)];
          run_max_q[CIW'(c)] <= (pix_ok && col_cnt == CW'(c)) ? I_luma : '0;
        end else if (pix_ok && col_cnt == CW'(c) && I_luma > run_max_q[CIW'(c)]) begin
          run_max_q[CIW'(c)] <= I_luma;
        end
      end
    end
  end

  zone_iir_clamp #(
    .FILT_SH  (FILT_SH),
    .MIN_LIGHT(MIN_LIGHT)
  ) u_iir_clamp (
    .o   (led_q[k_q]),
    .r   (raw_q[k_q]),
    .mode(mode_q),
    .w   (commit_val)
  );

  // Commit: one zone written per cycle
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int z = 0; z < NUM_ZONES; z++) led_q[KW'(z)] <= LIGHT_W'(MIN_LIGHT);
    end else if (state_q == ST_COMMIT) begin
      led_q[k_q] <= commit_val;
    end
  end

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_flat
    assign O_led_light[LIGHT_W*z +: LIGHT_W] = led_q[z];
  end

  assign O_frame_done = done_q;
  assign O_frame_err  = err_q;
  assign O_busy       = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_zone_light_calc.sv
// Scoreboard bench for zone_light_calc on a reduced 48x30 raster (2x2-pixel zones).
module tb_zone_light_calc;

  localparam int H_ACT = 48;
  localparam int V_ACT = 30;
  localparam int NZ    = 360;
  localparam int HOT_X = 3;   // zone column 1
  localparam int HOT_L = 5;   // zone row 2 -> zone 49

  logic            clk = 1'b0;
  logic            rst, vs, de;
  logic [7:0]      luma;
  logic [1:0]      mode;
  logic [8*NZ-1:0] led;
  logic            done, err, busy;

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;

  typedef struct {
    bit              is_err;
    logic [8*NZ-1:0] vec;
    string           name;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_led [NZ];

  zone_light_calc #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .ZONE_COLS(24), .ZONE_ROWS(15),
    .FILT_SH(2), .MIN_LIGHT(8)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_vs(vs), .I_de(de), .I_luma(luma), .I_mode(mode),
    .O_led_light(led), .O_frame_done(done), .O_frame_err(err), .O_busy(busy)
  );

  always #10 clk = ~clk;

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [8*NZ-1:0] pack_exp();
    logic [8*NZ-1:0] v;
    for (int z = 0; z < NZ; z++) v[8*z +: 8] = exp_led[z];
    return v;
  endfunction

  // kind 0: uniform frame of val; kind 1: black frame with one 255 pixel in zone 49
  function automatic void apply_commit(int m, int kind, int val);
    int r, f;
    for (int z = 0; z < NZ; z++) begin
      r = (kind == 0) ? val : ((z == 49) ? 255 : 0);
      case (m)
        0:       f = (exp_led[z] * 3 + r) / 4;
        1:       f = r;
        2:       f = 255;
        default: f = exp_led[z];
      endcase
      if (f < 8) f = 8;
      exp_led[z] = 8'(f);
    end
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic push_exp(input bit is_err, input string nm);
    exp_t e;
    e.is_err = is_err;
    e.vec    = pack_exp();
    e.name   = nm;
    sb_q.push_back(e);
  endtask

  task automatic vsync();
    @(posedge clk); #1 vs = 1'b1;
    repeat (2) @(posedge clk);
    #1 vs = 1'b0;
    repeat (380) @(posedge clk);
  endtask

  task automatic send_frame(input int kind, input int val, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < H_ACT; x++) begin
        @(posedge clk); #1;
        de   = 1'b1;
        luma = (kind == 0) ? 8'(val) : ((x == HOT_X && l == HOT_L) ? 8'd255 : 8'd0);
      end
      @(posedge clk); #1 de = 1'b0; luma = 8'd0;
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic commit_frame(input string nm, input int m, input int kind, input int val);
    #1 mode = 2'(m);
    send_frame(kind, val, V_ACT);
    apply_commit(m, kind, val);
    push_exp(1'b0, nm);
    vsync();
  endtask

  // Monitor: pops the scoreboard on every done/err pulse
  always @(negedge clk) begin : monitor
    exp_t e;
    int   nbad, first;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done || err) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: done=%0b err=%0b with empty scoreboard", done, err);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_kind_err"}, int'(err), int'(e.is_err));
          if (!e.is_err) chk({e.name, "_busy_cycles"}, busy_cnt, 360);
          nbad = 0; first = -1;
          for (int z = 0; z < NZ; z++)
            if (led[8*z +: 8] != e.vec[8*z +: 8]) begin
              nbad++;
              if (first < 0) first = z;
            end
          total++;
          if (nbad != 0) begin
            bad++;
            $display("FAIL %s_zones: %0d zones differ, zone %0d got %0d expected %0d",
                     e.name, nbad, first, led[8*first +: 8], e.vec[8*first +: 8]);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; vs = 1'b0; de = 1'b0; luma = 8'd0; mode = 2'd1;
    for (int z = 0; z < NZ; z++) exp_led[z] = 8'd8;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("reset_led_vector", int'(led == {NZ{8'd8}}), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);

    vsync();
    commit_frame("uniform_raw_a", 1, 0, 200);
    commit_frame("uniform_raw_b", 1, 0, 200);
    @(negedge clk);
    chk("uniform_zone0", int'(led[7:0]), 200);

    commit_frame("hot_pixel", 1, 1, 0);
    @(negedge clk);
    chk("hot_zone49", int'(led[8*49 +: 8]), 255);
    chk("hot_zone48_floor", int'(led[8*48 +: 8]), 8);
    chk("hot_zone73_floor", int'(led[8*73 +: 8]), 8);

    commit_frame("iir_1", 0, 0, 200);
    @(negedge clk);
    chk("iir1_zone0", int'(led[7:0]), 56);
    commit_frame("iir_2", 0, 0, 200);
    @(negedge clk);
    chk("iir2_zone0", int'(led[7:0]), 92);

    #1 mode = 2'd1;
    send_frame(0, 50, 10);
    push_exp(1'b1, "truncated");
    vsync();

    commit_frame("full_on", 2, 0, 77);
    commit_frame("hold", 3, 0, 100);
    @(negedge clk);
    chk("hold_zone359", int'(led[8*359 +: 8]), 255);

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d outstanding expected 0", sb_q.size());
    end
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zone_light_calc.md
Name: zone_light_calc

Overview:
- Upstream stage of MiniLED_driver. Consumes the active-video luma stream and computes one 8-bit backlight level per zone for the 24x15 = 360-zone panel.
- Per-zone statistic is the peak luma. An optional temporal IIR filter and a mode override are applied on top.
- Delivers the flattened 8*360-bit I_led_light vector plus a frame-commit pulse.
- Runs on the 50 MHz system clock (I_clk).

Parameters:
- H_ACT, 1920, active pixels per line
- V_ACT, 1080, active lines per frame
- ZONE_COLS, 24, zone columns
- ZONE_ROWS, 15, zone rows (ZONE_COLS*ZONE_ROWS must equal 360)
- FILT_SH, 2, IIR shift; 0 disables the filter
- MIN_LIGHT, 8, floor applied to every committed zone value

Ports:
- I_clk  in  1  system clock, 50 MHz
- I_rst  in  1  synchronous reset, active-high
- I_vs  in  1  vertical sync, active-high; rising edge marks frame start
- I_de  in  1  data enable; high marks an active pixel
- I_luma  in  8  pixel luma, valid when I_de=1
- I_mode  in  2  0=filtered, 1=raw peak, 2=full-on, 3=hold
- O_led_light  out  2880  zone k=row*24+col occupies bits [8k+7:8k]
- O_frame_done  out  1  one-cycle pulse when the commit finishes
- O_frame_err  out  1  one-cycle pulse when a malformed frame is discarded
- O_busy  out  1  high during the commit state

Behaviour:
- Derived zone sizes: ZONE_W = H_ACT/ZONE_COLS (80) and ZONE_H = V_ACT/ZONE_ROWS (72). Both must be exact integers; this is enforced by an elaboration-time check.
- Reset (I_rst=1 at a clock edge):
  - O_led_light = all zones MIN_LIGHT.
  - O_frame_done = O_frame_err = O_busy = 0.
  - FSM to IDLE; all counters, running maxima and raw store cleared.
- Reset mid-commit or mid-frame aborts immediately. No partial result is kept beyond the reset values.
- FSM states: IDLE -> ACC -> COMMIT -> ACC ...
  - IDLE to ACC: on the first I_vs rising edge.
  - ACC to COMMIT: on each I_vs rising edge, if the frame just finished was complete (line counter == V_ACT). Otherwise pulse O_frame_err, stay in ACC and keep O_led_light unchanged.
  - Every I_vs rising edge clears x, line and zone counters and all running maxima.
  - COMMIT to ACC: after 360 cycles, k = 0..359, one zone per cycle. O_frame_done pulses on the cycle after k=359 is written.
- Accumulation (ACC, I_de=1):
  - x counter runs 0..H_ACT-1; zone column = x/ZONE_W, tracked by a sub-counter with no divider.
  - run_max[col] = max(run_max[col], I_luma).
  - Pixels with x >= H_ACT are ignored.
  - Lines with line >= V_ACT are ignored and mark the frame malformed.
- Line end (I_de falling edge): line counter +1 and x cleared. A line with x != H_ACT also marks the frame malformed.
- Zone-row close: when a line ends and (line+1) % ZONE_H == 0:
  - raw[zrow*24 + c] = run_max[c] for all 24 columns in that same cycle.
  - run_max is cleared, zrow +1.
- Pixel on the same cycle as the close: if I_de rises on the same cycle as a zone-row close, the clear takes precedence and the new pixel is max'ed into the cleared value.
- Commit for zone k, with o = current O_led_light zone k and r = raw[k], according to I_mode sampled on entry to COMMIT:
  - mode 0: f = (o*(2^FILT_SH-1) + r) >> FILT_SH, computed in 8+FILT_SH bits with truncation; FILT_SH=0 gives f = r.
  - mode 1: f = r.
  - mode 2: f = 255.
  - mode 3: f = o, and nothing changes.
  - Written value = max(f, MIN_LIGHT).
- Malformed or extra data during COMMIT: if I_de=1 during COMMIT, the commit still completes, but the frame in progress is marked malformed. A second I_vs during COMMIT is latched and handled on return to ACC.
- Output stability: O_led_light changes only during COMMIT, one zone per cycle.

Decomposition:
- Package zone_light_pkg:
  - constants NUM_ZONES=360, ZONE_W and ZONE_H derivations;
  - the mode encodings MODE_FILT, MODE_RAW, MODE_FULL, MODE_HOLD;
  - the FSM state typedef.
- One sub-module, zone_iir_clamp: a combinational filter/mode/clamp datapath taking (o, r, mode) and producing the written value.
- Counters, FSM and storage stay in the top level.

Test Plan:
- Reset check: assert I_rst, release, then send no video -> O_led_light = 360 x 8'd8, O_busy=0, no pulses.
- Uniform raw frame: mode 1, two complete frames with I_luma=200 everywhere -> after the third I_vs, O_busy=1 for exactly 360 cycles, then O_frame_done pulses and every zone = 200.
- Single hot pixel: mode 1, I_luma=0 except 255 at x=85, line=150 -> zone 2*24+1=49 = 255; all other zones = 8 (MIN_LIGHT floor).
- IIR filter: FILT_SH=2, mode 0, zone history 8 then a raw frame of 200 -> zone = (8*3+200)>>2 = 56; a second 200 frame -> (56*3+200)>>2 = 92.
- Truncated frame: I_vs arrives after 1000 lines -> O_frame_err pulses, no COMMIT, O_led_light unchanged.
- Mode overrides: mode 2 -> all zones 255 after commit; then mode 3 with a different frame -> values stay 255 and O_frame_done still pulses.
